mem_stage_lsu: RTL and testbench

//  Load/store unit for the ArcheV memory stage, directly upstream of the data memory.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/mem_stage_lsu_byte_lane_unit.sv | 39 +++
 rtl/mem_stage_lsu.sv | 194 +++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the ArcheV memory-stage load/store unit:
//   - DATA_W / LANE_W : datapath width (two 8-bit byte lanes)
//   - lsu_op_e        : request opcode encoding from execute
//   - lsu_state_e     : LSU control FSM state encoding
//   - is_misaligned() : word ops are illegal on odd byte addresses
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam int DATA_W = 16;
    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LB = 2'b10,
        OP_SB = 2'b11
    } lsu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    // Byte ops can address either lane; only full-word ops need an even address.
    function automatic logic is_misaligned(input logic [1:0] op, input logic addr_lsb);
        return addr_lsb && ((op == OP_LW) || (op == OP_SW));
    endfunction

endpackage

// File: rtl/mem_stage_lsu_byte_lane_unit.sv
// ---------------------------------------------------------------------------
// byte_lane_unit (combinational)
// Little-endian byte-lane helper: lane 0 = bits[7:0], lane 1 = bits[15:8].
// Ports:
//   i_word   : word read from data memory
//   i_lane   : selected byte lane (byte address bit 0)
//   i_signed : 1 = sign-extend the loaded byte, 0 = zero-extend
//   i_wbyte  : store byte for SB
//   o_load   : selected byte, extended to a full word
//   o_merged : i_word with the selected lane replaced by i_wbyte
// ---------------------------------------------------------------------------
module byte_lane_unit (
    input  logic [15:0] i_word,
    input  logic        i_lane,
    input  logic        i_signed,
    input  logic [7:0]  i_wbyte,
    output logic [15:0] o_load,
    output logic [15:0] o_merged
);
    import lsu_pkg::*;

    logic [LANE_W-1:0] w_byte;

    // Lane extraction with sign/zero extension, and lane merge for byte stores.
    always_comb begin
        w_byte   = 8'h00;
        o_load   = 16'h0000;
        o_merged = i_word;
        if (i_lane) begin
            w_byte   = i_word[15:8];
            o_merged = {i_wbyte, i_word[7:0]};
        end else begin
            w_byte   = i_word[7:0];
            o_merged = {i_word[15:8], i_wbyte};
        end
        o_load = {{8{i_signed & w_byte[7]}}, w_byte};
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
// Load/store unit for the ArcheV memory stage. Takes one request at a time
// from execute, drives a single-port combinational-read data memory, and
// returns one response to writeback. Byte stores are read-modify-write.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   req_*              : execute request channel (valid/ready), latched on accept
//   resp_*             : writeback response channel (valid/ready), held until taken
//   mem_access_addr    : word address (byte address >> 1), registered
//   mem_write_data     : registered write data
//   mem_write_en       : write strobe, memory commits at the end of the cycle
//   mem_read           : read enable, mem_read_data valid in the same cycle
//   mem_read_data      : combinational read data from memory
// Only DATA_W = 16 (two byte lanes) is supported.
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);
    import lsu_pkg::*;

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;

    logic [1:0]        r_op;
    logic              r_signed;
    logic              r_lane;
    logic [7:0]        r_wbyte;

    logic              r_mem_read;
    logic              r_mem_write_en;
    logic [ADDR_W-1:0] r_mem_access_addr;
    logic [DATA_W-1:0] r_mem_write_data;
    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_mem_read_nxt;
    logic              w_mem_write_en_nxt;
    logic              w_resp_valid_nxt;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_merged;

    assign req_ready       = (r_state == ST_IDLE);
    assign w_accept        = req_valid && req_ready;
    assign w_misaligned    = is_misaligned(req_op, req_addr[0]);

    assign mem_read        = r_mem_read;
    assign mem_write_en    = r_mem_write_en;
    assign mem_access_addr = r_mem_access_addr;
    assign mem_write_data  = r_mem_write_data;
    assign resp_valid      = r_resp_valid;
    assign resp_rdata      = r_resp_rdata;
    assign resp_err        = r_resp_err;

    byte_lane_unit u_lane (
        .i_word   (mem_read_data),
        .i_lane   (r_lane),
        .i_signed (r_signed),
        .i_wbyte  (r_wbyte),
        .o_load   (w_load_ext),
        .o_merged (w_merged)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_nxt = ST_RESP;
                    end else begin
                        case (req_op)
                            OP_LW:   w_state_nxt = ST_RD;
                            OP_LB:   w_state_nxt = ST_RD;
                            OP_SW:   w_state_nxt = ST_WR;
                            OP_SB:   w_state_nxt = ST_RMW_RD;
                            default: w_state_nxt = ST_IDLE;
                        endcase
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD:     w_state_nxt = ST_RESP;
            ST_WR:     w_state_nxt = ST_RESP;
            ST_RMW_RD: w_state_nxt = ST_RMW_WR;
            ST_RMW_WR: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode: strobes are a pure function of the state being entered,
    // registered alongside it so they are glitch-free and mutually exclusive.
    always_comb begin
        w_mem_read_nxt     = 1'b0;
        w_mem_write_en_nxt = 1'b0;
        w_resp_valid_nxt   = 1'b0;
        case (w_state_nxt)
            ST_RD:     w_mem_read_nxt     = 1'b1;
            ST_RMW_RD: w_mem_read_nxt     = 1'b1;
            ST_WR:     w_mem_write_en_nxt = 1'b1;
            ST_RMW_WR: w_mem_write_en_nxt = 1'b1;
            ST_RESP:   w_resp_valid_nxt   = 1'b1;
            default: begin
                w_mem_read_nxt     = 1'b0;
                w_mem_write_en_nxt = 1'b0;
                w_resp_valid_nxt   = 1'b0;
            end
        endcase
    end

    // Registered strobes; async reset drops a pending write strobe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_read     <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_resp_valid   <= 1'b0;
        end else begin
            r_mem_read     <= w_mem_read_nxt;
            r_mem_write_en <= w_mem_write_en_nxt;
            r_resp_valid   <= w_resp_valid_nxt;
        end
    end

    // Request latch, memory-side address/data and response data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op              <= 2'b00;
            r_signed          <= 1'b0;
            r_lane            <= 1'b0;
            r_wbyte           <= 8'h00;
            r_mem_access_addr <= {ADDR_W{1'b0}};
            r_mem_write_data  <= {DATA_W{1'b0}};
            r_resp_rdata      <= {DATA_W{1'b0}};
            r_resp_err        <= 1'b0;
        end else if (w_accept) begin
            r_op              <= req_op;
            r_signed          <= req_signed;
            r_lane            <= req_addr[0];
            r_wbyte           <= req_wdata[7:0];
            r_mem_access_addr <= {1'b0, req_addr[ADDR_W-1:1]};
            // SB overwrites this with the merged word at the end of RMW_RD.
            r_mem_write_data  <= (req_op == OP_SW) ? req_wdata : {DATA_W{1'b0}};
            r_resp_rdata      <= {DATA_W{1'b0}};
            r_resp_err        <= w_misaligned;
        end else if (r_state == ST_RD) begin
            r_resp_rdata      <= (r_op == OP_LW) ? mem_read_data : w_load_ext;
        end else if (r_state == ST_RMW_RD) begin
            r_mem_write_data  <= w_merged;
        end else begin
            r_resp_rdata      <= r_resp_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
// Directed bench for mem_stage_lsu with an 8-word combinational-read memory.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_signed;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    int vectors;
    int miscompares;

    logic [15:0] mem [0:7];
    int          wr_cnt;
    int          rd_cnt;
    int          both_cnt;
    logic [15:0] last_wr_addr;

    mem_stage_lsu #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_err        (resp_err),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: decodes the low 3 word-address bits only.
    assign mem_read_data = mem[mem_access_addr[2:0]];

    always @(posedge clk) begin
        if (mem_write_en) begin
            mem[mem_access_addr[2:0]] <= mem_write_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_access_addr;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (mem_read && mem_write_en) both_cnt <= both_cnt + 1;
    end

    // Present one request, scramble inputs after accept, wait (bounded) for resp_valid.
    // Returns at a falling edge with the response still pending.
    task automatic do_req(input logic [1:0] op, input logic sgn, input logic [15:0] addr,
                          input logic [15:0] wd, output int lat, output logic [15:0] rd,
                          output logic er);
        @(negedge clk);
        req_valid  = 1'b1;
        req_op     = op;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_signed = ~sgn;
        req_addr   = 16'hFFFF;
        req_wdata  = 16'h5A5A;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_signed = 1'b0;
        req_addr = 16'h0000; req_wdata = 16'h0000; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
        vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write_en got=%b exp=0", mem_write_en); end
        vectors++; if (mem_access_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_access_addr); end
        vectors++; if (resp_rdata !== 16'h0000 || resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp got=%h/%b exp=0000/0", resp_rdata, resp_err); end
    endtask

    task automatic test_sw_lw();
        int lat; logic [15:0] rd; logic er; int w0;
        w0 = wr_cnt;
        do_req(2'b01, 1'b0, 16'h0004, 16'hBEEF, lat, rd, er);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL sw_latency got=%0d exp=2", lat); end
        vectors++; if (rd !== 16'h0000 || er !== 1'b0) begin miscompares++; $display("FAIL sw_resp got=%h/%b exp=0000/0", rd, er); end
        consume();
        vectors++; if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL sw_write_count got=%0d exp=1", wr_cnt - w0); end
        vectors++; if (last_wr_addr !== 16'h0002) begin miscompares++; $display("FAIL sw_word_addr got=%h exp=0002", last_wr_addr); end
        do_req(2'b00, 1'b0, 16'h0004, 16'h0000, lat, rd, er);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL lw_latency got=%0d exp=2", lat); end
        vectors++; if (rd !== 16'hBEEF || er !== 1'b0) begin miscompares++; $display("FAIL lw_data got=%h/%b exp=beef/0", rd, er); end
        consume();
    endtask

    task automatic test_lb();
        int lat; logic [15:0] rd; logic er;
        do_req(2'b01, 1'b0, 16'h0004, 16'h80F1, lat, rd, er);
        consume();
        do_req(2'b10, 1'b1, 16'h0004, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'hFFF1 || lat !== 2) begin miscompares++; $display("FAIL lb_lane0_signed got=%h lat=%0d exp=fff1 lat=2", rd, lat); end
        consume();
        do_req(2'b10, 1'b0, 16'h0005, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'h0080 || er !== 1'b0) begin miscompares++; $display("FAIL lb_lane1_unsigned got=%h/%b exp=0080/0", rd, er); end
        consume();
        do_req(2'b10, 1'b1, 16'h0005, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'hFF80) begin miscompares++; $display("FAIL lb_lane1_signed got=%h exp=ff80", rd); end
        consume();
    endtask

    task automatic test_sb();
        int lat; logic [15:0] rd; logic er; int w0; int r0;
        do_req(2'b01, 1'b0, 16'h0006, 16'h1234, lat, rd, er);
        consume();
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(2'b11, 1'b0, 16'h0007, 16'h00AB, lat, rd, er);
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL sb_latency got=%0d exp=3", lat); end
        vectors++; if (rd !== 16'h0000 || er !== 1'b0) begin miscompares++; $display("FAIL sb_resp got=%h/%b exp=0000/0", rd, er); end
        consume();
        vectors++; if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin miscompares++; $display("FAIL sb_rmw_counts got=wr%0d rd%0d exp=wr1 rd1", wr_cnt - w0, rd_cnt - r0); end
        vectors++; if (last_wr_addr !== 16'h0003) begin miscompares++; $display("FAIL sb_word_addr got=%h exp=0003", last_wr_addr); end
        do_req(2'b00, 1'b0, 16'h0006, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'hAB34) begin miscompares++; $display("FAIL sb_merged_word got=%h exp=ab34", rd); end
        consume();
    endtask

    task automatic test_misaligned();
        int lat; logic [15:0] rd; logic er; int w0; int r0;
        w0 = wr_cnt; r0 = rd_cnt;
        do_req(2'b00, 1'b0, 16'h0003, 16'h0000, lat, rd, er);
        vectors++; if (lat !== 1) begin miscompares++; $display("FAIL mis_lw_latency got=%0d exp=1", lat); end
        vectors++; if (er !== 1'b1 || rd !== 16'h0000) begin miscompares++; $display("FAIL mis_lw_resp got=%h/%b exp=0000/1", rd, er); end
        consume();
        do_req(2'b01, 1'b0, 16'h0005, 16'hDEAD, lat, rd, er);
        vectors++; if (er !== 1'b1 || lat !== 1) begin miscompares++; $display("FAIL mis_sw_resp got=err%b lat%0d exp=err1 lat1", er, lat); end
        consume();
        vectors++; if (wr_cnt !== w0 || rd_cnt !== r0) begin miscompares++; $display("FAIL mis_no_access got=wr%0d rd%0d exp=wr0 rd0", wr_cnt - w0, rd_cnt - r0); end
    endtask

    task automatic test_backpressure();
        int lat; logic [15:0] rd; logic er; int r0;
        do_req(2'b00, 1'b0, 16'h0006, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'hAB34 || lat !== 2) begin miscompares++; $display("FAIL bp_first got=%h lat=%0d exp=ab34 lat=2", rd, lat); end
        r0 = rd_cnt;
        req_valid = 1'b1; req_op = 2'b00; req_addr = 16'h0004;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== 16'hAB34 || req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d got=v%b d%h rdy%b exp=v1 dab34 rdy0", i, resp_valid, resp_rdata, req_ready);
            end
        end
        req_valid = 1'b0;
        vectors++; if (rd_cnt !== r0) begin miscompares++; $display("FAIL bp_no_accept got=%0d reads exp=0", rd_cnt - r0); end
        consume();
    endtask

    task automatic test_rst_during_wr();
        int lat; logic [15:0] rd; logic er; int w0;
        do_req(2'b01, 1'b0, 16'h0002, 16'h1111, lat, rd, er);
        consume();
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 16'h0002; req_wdata = 16'h2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++; if (mem_write_en !== 1'b1) begin miscompares++; $display("FAIL rst_wr_strobe_pre got=%b exp=1", mem_write_en); end
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (mem_write_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_strobe_drop got=%b exp=0", mem_write_en); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (wr_cnt !== w0 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wr_no_write got=wr%0d v%b exp=wr0 v0", wr_cnt - w0, resp_valid); end
        do_req(2'b00, 1'b0, 16'h0002, 16'h0000, lat, rd, er);
        vectors++; if (rd !== 16'h1111) begin miscompares++; $display("FAIL rst_wr_word_kept got=%h exp=1111", rd); end
        consume();
        vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL read_write_overlap got=%0d exp=0", both_cnt); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_sw_lw();
        test_lb();
        test_sb();
        test_misaligned();
        test_backpressure();
        test_rst_during_wr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
